// File: rtl/dram_bank_tracker_if.sv
// Scheduler-facing bus of the DRAM bank tracker: command request/legality
// and the zero-latency open-row lookup port.
interface dram_bank_tracker_if #(
   parameter int NUM_BANKS = 16,
   parameter int ROW_BITS  = 15
);
   localparam int BANK_W = $clog2(NUM_BANKS);

   logic                cmd_valid;
   logic [2:0]          cmd;
   logic [BANK_W-1:0]   cmd_bank;
   logic [ROW_BITS-1:0] cmd_row;
   logic                cmd_legal;
   logic                cmd_err;
   logic [BANK_W-1:0]   q_bank;
   logic [ROW_BITS-1:0] q_row;
   logic                q_open;
   logic                q_hit;

   modport master (output cmd_valid, cmd, cmd_bank, cmd_row, q_bank, q_row,
                   input  cmd_legal, cmd_err, q_open, q_hit);
   modport slave  (input  cmd_valid, cmd, cmd_bank, cmd_row, q_bank, q_row,
                   output cmd_legal, cmd_err, q_open, q_hit);
endinterface

// File: rtl/dram_bank_tracker.sv
// Per-bank DRAM row state and timing tracker: judges command legality,
// drives read/write data windows and keeps refresh debt.
module dram_bank_tracker #(
   parameter int NUM_BANKS    = 16,
   parameter int ROW_BITS     = 15,
   parameter int T_RCD        = 10,
   parameter int T_RAS        = 10,
   parameter int T_RP         = 10,
   parameter int T_WR         = 12,
   parameter int T_RL         = 11,
   parameter int T_WL         = 11,
   parameter int T_BURST      = 4,
   parameter int T_RFC        = 10,
   parameter int T_REFI       = 96000,
   parameter int MAX_POSTPONE = 8
) (
   input  logic                 CLK,
   input  logic                 nRST,
   dram_bank_tracker_if.slave   bus,
   output logic [NUM_BANKS-1:0] bank_idle,
   output logic                 rd_data_en,
   output logic                 wr_data_en,
   output logic                 ref_req,
   output logic                 ref_urgent
);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int T_WREC = T_WL + T_BURST + T_WR;
   localparam int CNT_W  = $clog2(T_RCD + T_RAS + T_RP + T_WREC + T_RFC + 1);
   localparam int RI_W   = $clog2(T_REFI + 1);
   localparam int DEBT_W = $clog2(MAX_POSTPONE + 1);
   localparam int RD_D   = T_RL + T_BURST - 1;
   localparam int WR_D   = T_WL + T_BURST - 1;

   typedef enum logic [2:0] {C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_PREA, C_REF, C_BAD} cmd_t;
   typedef enum logic [1:0] {IDLE, ACTIVATING, ACTIVE, PRECHARGING} bank_st_t;

   logic [NUM_BANKS-1:0]               act_ok, col_ok, pre_ok, is_open;
   logic [NUM_BANKS-1:0][ROW_BITS-1:0] open_row;
   logic [CNT_W-1:0]                   spacing, rfc;
   logic [RI_W-1:0]                    interval;
   logic [DEBT_W-1:0]                  debt;
   logic [RD_D:1]                      rd_pipe;
   logic [WR_D:1]                      wr_pipe;
   logic                               legal, acc, rfc_clr, do_rd, do_wr, do_ref, ref_tick;
   cmd_t                               op;

   assign op      = cmd_t'(bus.cmd);
   assign rfc_clr = (rfc == '0);

   always_comb begin
      legal = 1'b0;
      case (op)
         C_NOP:      legal = 1'b1;
         C_ACT:      legal = act_ok[bus.cmd_bank] && rfc_clr;
         C_RD, C_WR: legal = col_ok[bus.cmd_bank] && (spacing == '0) && rfc_clr;
         C_PRE:      legal = pre_ok[bus.cmd_bank] && rfc_clr;
         C_PREA:     legal = (&pre_ok) && rfc_clr;
         C_REF:      legal = (&act_ok) && rfc_clr;
         default:    legal = 1'b0;
      endcase
   end

   assign bus.cmd_legal = legal;
   assign acc      = bus.cmd_valid && legal;
   assign do_rd    = acc && (op == C_RD);
   assign do_wr    = acc && (op == C_WR);
   assign do_ref   = acc && (op == C_REF);
   assign ref_tick = (interval == '0);

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      bank_st_t          st, st_nx;
      logic [CNT_W-1:0]  rcd_rp, ras, wrec;
      logic [ROW_BITS-1:0] row;
      logic              sel, do_act, do_pre, do_bwr;

      assign sel    = (bus.cmd_bank == BANK_W'(b));
      assign do_act = acc && (op == C_ACT) && sel;
      // PRE/PREA on a closed bank is accepted but leaves it untouched
      assign do_pre = acc && (st == ACTIVE) && ((op == C_PREA) || ((op == C_PRE) && sel));
      assign do_bwr = do_wr && sel;

      // Leave ACTIVATING/PRECHARGING as the shared count hits its last tick so
      // the follow-on command is legal exactly tRCD/tRP after the opener.
      always_comb begin
         st_nx = st;
         case (st)
            IDLE:        if (do_act) st_nx = ACTIVATING;
            ACTIVATING:  if (rcd_rp <= CNT_W'(1)) st_nx = ACTIVE;
            ACTIVE:      if (do_pre) st_nx = PRECHARGING;
            PRECHARGING: if (rcd_rp <= CNT_W'(1)) st_nx = IDLE;
            default:     st_nx = IDLE;
         endcase
      end

      always_ff @(posedge CLK or negedge nRST) begin
         if (!nRST) st <= IDLE;
         else       st <= st_nx;
      end

      always_ff @(posedge CLK or negedge nRST) begin
         if (!nRST) begin
            rcd_rp <= '0;
            ras    <= '0;
            wrec   <= '0;
            row    <= '0;
         end else begin
            if (do_act) begin
               rcd_rp <= CNT_W'(T_RCD - 1);
               ras    <= CNT_W'(T_RAS - 1);
               row    <= bus.cmd_row;
            end else begin
               if (do_pre)              rcd_rp <= CNT_W'(T_RP - 1);
               else if (rcd_rp != '0)   rcd_rp <= rcd_rp - 1'b1;
               if (ras != '0)           ras    <= ras - 1'b1;
            end
            if (do_bwr)           wrec <= CNT_W'(T_WREC - 1);
            else if (wrec != '0)  wrec <= wrec - 1'b1;
         end
      end

      assign act_ok[b]    = (st == IDLE) && (rcd_rp == '0);
      assign col_ok[b]    = (st == ACTIVE);
      assign pre_ok[b]    = (st == IDLE) || ((st == ACTIVE) && (ras == '0) && (wrec == '0));
      assign is_open[b]   = (st == ACTIVE) || (st == ACTIVATING);
      assign bank_idle[b] = (st == IDLE);
      assign open_row[b]  = row;
   end

   assign bus.q_open = is_open[bus.q_bank];
   assign bus.q_hit  = bus.q_open && (open_row[bus.q_bank] == bus.q_row);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         spacing     <= '0;
         rfc         <= '0;
         interval    <= RI_W'(T_REFI - 1);
         debt        <= '0;
         rd_pipe     <= '0;
         wr_pipe     <= '0;
         bus.cmd_err <= 1'b0;
      end else begin
         if (do_rd || do_wr)     spacing <= CNT_W'(T_BURST - 1);
         else if (spacing != '0) spacing <= spacing - 1'b1;
         if (do_ref)             rfc <= CNT_W'(T_RFC - 1);
         else if (rfc != '0)     rfc <= rfc - 1'b1;
         interval <= ref_tick ? RI_W'(T_REFI - 1) : interval - 1'b1;
         // an interval expiry and an accepted REF in the same cycle cancel out
         if (ref_tick && !do_ref && (debt != DEBT_W'(MAX_POSTPONE))) debt <= debt + 1'b1;
         else if (do_ref && !ref_tick && (debt != '0))               debt <= debt - 1'b1;
         rd_pipe     <= {rd_pipe[RD_D-1:1], do_rd};
         wr_pipe     <= {wr_pipe[WR_D-1:1], do_wr};
         bus.cmd_err <= bus.cmd_valid && !legal;
      end
   end

   assign rd_data_en = |rd_pipe[RD_D:T_RL];
   assign wr_data_en = |wr_pipe[WR_D:T_WL];
   assign ref_req    = (debt != '0);
   assign ref_urgent = (debt == DEBT_W'(MAX_POSTPONE));
endmodule

// File: tb/tb_dram_bank_tracker.sv
// Randomized and directed bench for dram_bank_tracker; the reference model keeps
// absolute "legal-from" cycle numbers per bank instead of countdown state.
module tb_dram_bank_tracker;
   localparam int NB = 16, RB = 15, BW = $clog2(NB);
   localparam int T_RCD = 10, T_RAS = 10, T_RP = 10, T_WR = 12, T_RL = 11, T_WL = 11;
   localparam int T_BURST = 4, T_RFC = 10, T_REFI = 100, MAXP = 8;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic [NB-1:0] bank_idle;
   logic          rd_data_en, wr_data_en, ref_req, ref_urgent;

   dram_bank_tracker_if #(.NUM_BANKS(NB), .ROW_BITS(RB)) bus ();

   dram_bank_tracker #(
      .NUM_BANKS(NB), .ROW_BITS(RB), .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP),
      .T_WR(T_WR), .T_RL(T_RL), .T_WL(T_WL), .T_BURST(T_BURST), .T_RFC(T_RFC),
      .T_REFI(T_REFI), .MAX_POSTPONE(MAXP)
   ) dut (
      .CLK(clk), .nRST(nrst), .bus(bus), .bank_idle(bank_idle),
      .rd_data_en(rd_data_en), .wr_data_en(wr_data_en),
      .ref_req(ref_req), .ref_urgent(ref_urgent)
   );

   always #5 clk = ~clk;

   int n_vec, n_err, cyc;
   bit          m_open[NB];
   logic [RB-1:0] m_row[NB];
   int          m_col[NB], m_pre[NB], m_act[NB];
   int          g_col, rfc_from, debt;
   bit          prev_err;
   int          rd_q[$], wr_q[$];

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   function automatic bit m_idle(int b);
      return !m_open[b] && (cyc >= m_act[b]);
   endfunction

   function automatic bit m_preok(int b);
      return m_idle(b) || (m_open[b] && cyc >= m_col[b] && cyc >= m_pre[b]);
   endfunction

   function automatic bit m_legal(logic [2:0] c, int b);
      bit rok = (cyc >= rfc_from);
      bit all_pre = 1'b1;
      bit all_idle = 1'b1;
      for (int i = 0; i < NB; i++) begin
         all_pre  &= m_preok(i);
         all_idle &= m_idle(i);
      end
      case (c)
         0:       return 1'b1;
         1:       return rok && !m_open[b] && cyc >= m_act[b];
         2, 3:    return rok && m_open[b] && cyc >= m_col[b] && cyc >= g_col;
         4:       return rok && m_preok(b);
         5:       return rok && all_pre;
         6:       return rok && all_idle;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit in_win(int q[$], int lat);
      foreach (q[i]) if (cyc >= q[i] + lat && cyc <= q[i] + lat + T_BURST - 1) return 1'b1;
      return 1'b0;
   endfunction

   task automatic mreset();
      for (int i = 0; i < NB; i++) begin
         m_open[i] = 0; m_row[i] = '0; m_col[i] = 0; m_pre[i] = 0; m_act[i] = 0;
      end
      g_col = 0; rfc_from = 0; debt = 0; prev_err = 0; cyc = 0;
      rd_q.delete(); wr_q.delete();
   endtask

   task automatic mcheck();
      logic [NB-1:0] iv;
      int qb;
      qb = int'(bus.q_bank);
      for (int i = 0; i < NB; i++) iv[i] = m_idle(i);
      chk("cmd_legal", bus.cmd_legal, m_legal(bus.cmd, int'(bus.cmd_bank)));
      chk("cmd_err", bus.cmd_err, prev_err);
      chk("q_open", bus.q_open, m_open[qb]);
      chk("q_hit", bus.q_hit, m_open[qb] && (m_row[qb] == bus.q_row));
      chk("bank_idle", bank_idle, iv);
      chk("rd_data_en", rd_data_en, in_win(rd_q, T_RL));
      chk("wr_data_en", wr_data_en, in_win(wr_q, T_WL));
      chk("ref_req", ref_req, debt > 0);
      chk("ref_urgent", ref_urgent, debt == MAXP);
   endtask

   task automatic mupdate();
      int b;
      bit lg, acc, dec, tick;
      b    = int'(bus.cmd_bank);
      lg   = m_legal(bus.cmd, b);
      acc  = bus.cmd_valid && lg;
      dec  = acc && (bus.cmd == 3'd6);
      tick = (cyc % T_REFI) == T_REFI - 1;
      prev_err = bus.cmd_valid && !lg;
      if (acc) begin
         case (bus.cmd)
            3'd1: begin
               m_open[b] = 1; m_row[b] = bus.cmd_row;
               m_col[b] = cyc + T_RCD; m_pre[b] = cyc + T_RAS;
            end
            3'd2: begin g_col = cyc + T_BURST; rd_q.push_back(cyc); end
            3'd3: begin
               g_col = cyc + T_BURST; wr_q.push_back(cyc);
               if (cyc + T_WL + T_BURST + T_WR > m_pre[b]) m_pre[b] = cyc + T_WL + T_BURST + T_WR;
            end
            3'd4: if (m_open[b]) begin m_open[b] = 0; m_act[b] = cyc + T_RP; end
            3'd5: for (int i = 0; i < NB; i++)
                     if (m_open[i]) begin m_open[i] = 0; m_act[i] = cyc + T_RP; end
            3'd6: rfc_from = cyc + T_RFC;
            default: ;
         endcase
      end
      if (tick && !dec && debt < MAXP)      debt++;
      else if (dec && !tick && debt > 0)    debt--;
      while (rd_q.size() > 0 && rd_q[0] + T_RL + T_BURST - 1 < cyc) void'(rd_q.pop_front());
      while (wr_q.size() > 0 && wr_q[0] + T_WL + T_BURST - 1 < cyc) void'(wr_q.pop_front());
      cyc++;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      bus.cmd_valid = 0; bus.cmd = '0; bus.cmd_bank = '0; bus.cmd_row = '0;
      bus.q_bank = '0; bus.q_row = '0;
      mreset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bank_idle", bank_idle, {NB{1'b1}});
      chk("rst_rd_en", rd_data_en, 0);
      chk("rst_wr_en", wr_data_en, 0);
      chk("rst_ref_req", ref_req, 0);
      chk("rst_ref_urgent", ref_urgent, 0);
      chk("rst_cmd_err", bus.cmd_err, 0);
      nrst = 1'b1;
   endtask

   task automatic put(bit v, logic [2:0] c, int b, logic [RB-1:0] r);
      int qb;
      qb = $urandom_range(0, NB - 1);
      bus.cmd_valid = v; bus.cmd = c; bus.cmd_bank = BW'(b); bus.cmd_row = r;
      bus.q_bank = BW'(qb);
      bus.q_row  = ($urandom_range(0, 1) == 1) ? m_row[qb] : RB'($urandom);
      @(negedge clk);
      mcheck();
   endtask

   task automatic adv();
      @(posedge clk);
      mupdate();
      #1;
   endtask

   task automatic step(bit v, logic [2:0] c, int b, logic [RB-1:0] r);
      put(v, c, b, r);
      adv();
   endtask

   task automatic nops_to(int t);
      while (cyc < t) step(1, 3'd0, 0, '0);
   endtask

   initial begin
      int r, b, rs;
      logic [2:0] c;
      logic [RB-1:0] row;
      bit v;
      n_vec = 0; n_err = 0;

      // ACT -> row hit, tRCD boundary, error pulse
      do_reset();
      step(1, 3'd1, 3, 15'h1234);
      put(1, 3'd0, 0, '0);
      bus.q_bank = BW'(3); bus.q_row = 15'h1234; #1;
      chk("t1_q_hit", bus.q_hit, 1);
      adv();
      nops_to(9);
      put(1, 3'd2, 3, '0); chk("t1_rd9", bus.cmd_legal, 0); adv();
      put(1, 3'd2, 3, '0); chk("t1_rd10", bus.cmd_legal, 1); chk("t1_err10", bus.cmd_err, 1); adv();
      nops_to(30);

      // read window and column spacing
      do_reset();
      step(1, 3'd1, 0, 15'h0042);
      nops_to(10);
      put(1, 3'd2, 0, '0); chk("t2_rd10", bus.cmd_legal, 1); adv();
      step(1, 3'd0, 0, '0);
      put(1, 3'd2, 0, '0); chk("t2_rd12", bus.cmd_legal, 0); adv();
      step(1, 3'd0, 0, '0);
      put(1, 3'd2, 0, '0); chk("t2_rd14", bus.cmd_legal, 1); adv();
      nops_to(20);
      put(1, 3'd0, 0, '0); chk("t2_en20", rd_data_en, 0); adv();
      put(1, 3'd0, 0, '0); chk("t2_en21", rd_data_en, 1); adv();
      nops_to(28);
      put(1, 3'd0, 0, '0); chk("t2_en28", rd_data_en, 1); adv();
      put(1, 3'd0, 0, '0); chk("t2_en29", rd_data_en, 0); adv();

      // write recovery then tRP
      do_reset();
      step(1, 3'd1, 0, 15'h0001);
      nops_to(10);
      step(1, 3'd3, 0, '0);
      nops_to(36);
      put(1, 3'd4, 0, '0); chk("t3_pre36", bus.cmd_legal, 0); adv();
      put(1, 3'd4, 0, '0); chk("t3_pre37", bus.cmd_legal, 1); adv();
      nops_to(46);
      put(1, 3'd1, 0, 15'h0005); chk("t3_act46", bus.cmd_legal, 0); adv();
      put(1, 3'd1, 0, 15'h0005); chk("t3_act47", bus.cmd_legal, 1); adv();

      // PREA across banks 1 and 5
      do_reset();
      step(1, 3'd1, 1, 15'h0007);
      step(1, 3'd1, 5, 15'h0009);
      nops_to(5);
      put(1, 3'd5, 0, '0); chk("t4_prea5", bus.cmd_legal, 0); adv();
      nops_to(10);
      put(1, 3'd5, 0, '0); chk("t4_prea10", bus.cmd_legal, 0); adv();
      put(1, 3'd5, 0, '0); chk("t4_prea11", bus.cmd_legal, 1); adv();
      put(1, 3'd0, 0, '0); chk("t4_idle12", bank_idle, 16'hFFDD); adv();
      nops_to(20);
      put(1, 3'd0, 0, '0); chk("t4_idle20", bank_idle, 16'hFFDD); adv();
      put(1, 3'd0, 0, '0); chk("t4_idle21", bank_idle, 16'hFFFF); adv();

      // refresh debt, saturation, REF blocking, reset mid-burst
      do_reset();
      nops_to(99);
      put(1, 3'd0, 0, '0); chk("t5_req99", ref_req, 0); adv();
      put(1, 3'd0, 0, '0); chk("t5_req100", ref_req, 1); adv();
      nops_to(799);
      put(1, 3'd0, 0, '0); chk("t5_urg799", ref_urgent, 0); adv();
      put(1, 3'd0, 0, '0); chk("t5_urg800", ref_urgent, 1); adv();
      nops_to(900);
      put(1, 3'd6, 0, '0); chk("t5_ref900", bus.cmd_legal, 1); adv();
      put(1, 3'd1, 0, 15'h0011); chk("t5_urg901", ref_urgent, 0); adv();
      while (cyc < 909) step(1, 3'd1, 0, 15'h0011);
      put(1, 3'd1, 0, 15'h0011); chk("t5_act909", bus.cmd_legal, 0); adv();
      put(1, 3'd1, 0, 15'h0011); chk("t5_act910", bus.cmd_legal, 1); adv();
      nops_to(920);
      step(1, 3'd2, 0, '0);
      nops_to(932);
      put(1, 3'd0, 0, '0);
      chk("t6_rd_on", rd_data_en, 1);
      chk("t6_req_on", ref_req, 1);
      #2 nrst = 1'b0;
      #1;
      chk("t6_rd_rst", rd_data_en, 0);
      chk("t6_req_rst", ref_req, 0);
      chk("t6_idle_rst", bank_idle, 16'hFFFF);
      chk("t6_open_rst", bus.q_open, 0);

      // randomized traffic
      do_reset();
      repeat (3000) begin
         r = $urandom_range(0, 99);
         if (r < 30)      c = 3'd1;
         else if (r < 55) c = 3'd2;
         else if (r < 70) c = 3'd3;
         else if (r < 82) c = 3'd4;
         else if (r < 87) c = 3'd5;
         else if (r < 91) c = 3'd6;
         else if (r < 93) c = 3'd7;
         else             c = 3'd0;
         b  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NB - 1) : $urandom_range(0, 3);
         rs = $urandom_range(0, 2);
         row = (rs == 0) ? 15'h1234 : (rs == 1) ? 15'h7FFF : RB'($urandom);
         v  = ($urandom_range(0, 9) != 0);
         step(v, c, b, row);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
